uart_rx_deserializer: RTL and testbench

Serial-in/parallel-out receive stage on the Rx side. It consumes the serial frame that the Tx PISO shift register produces: start bit, data bits sent LSB first, an optional parity bit, and one stop bit. It oversamples the line, recovers data_length bits, checks parity and framing, and presents the word with a one-cycle valid strobe to the Rx consumer.

---
 rtl/uart_rx_deserializer.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
//   Oversampling UART receive stage: start bit, 1..8 data bits LSB first,
//   optional parity bit, one stop bit. The assembled word is presented with
//   a one-cycle valid strobe together with parity and framing flags.
//
// Ports
//   baud_clk        in   clock at OVERSAMPLE x bit rate
//   resetn          in   synchronous active-low reset
//   serial_data_in  in   asynchronous serial line, idle high
//   data_length     in   data bits per frame, 1..8 (0 or >8 means 8)
//   parity_type     in   0 even, 1 odd, 2 none, 3 present but unchecked
//   data            out  received word, right-aligned, upper bits zero
//   data_valid      out  one-cycle pulse when data and flags update
//   parity_error    out  parity mismatch of the last frame
//   framing_error   out  stop bit sampled low in the last frame
//   rx_busy         out  receiver is not idle
module uart_rx_deserializer #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       baud_clk,
    input  logic       resetn,
    input  logic       serial_data_in,
    input  logic [3:0] data_length,
    input  logic [1:0] parity_type,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       rx_busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t          state, state_n;
    logic            sync1, rx_s;
    logic [TW-1:0]   tick_cnt, tick_n;
    logic [3:0]      bit_cnt, bit_n;
    logic [7:0]      shreg, shreg_n;
    logic [3:0]      len_q, len_n;
    logic [1:0]      par_q, par_n;
    logic            rx_par, rx_par_n;
    logic [7:0]      data_n;
    logic            data_valid_n, parity_error_n, framing_error_n;
    logic [3:0]      len_clamped;
    logic            word_par;

    assign len_clamped = (data_length == 4'd0 || data_length > 4'd8) ? 4'd8 : data_length;
    assign word_par    = (^shreg) ^ rx_par;
    assign rx_busy     = (state != IDLE);

    // Two-flop synchronizer; both stages reset to the idle line level.
    always_ff @(posedge baud_clk) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= serial_data_in;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge baud_clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge baud_clk) begin
        if (!resetn) begin
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            len_q         <= 4'd8;
            par_q         <= 2'd2;
            rx_par        <= 1'b0;
            data          <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            tick_cnt      <= tick_n;
            bit_cnt       <= bit_n;
            shreg         <= shreg_n;
            len_q         <= len_n;
            par_q         <= par_n;
            rx_par        <= rx_par_n;
            data          <= data_n;
            data_valid    <= data_valid_n;
            parity_error  <= parity_error_n;
            framing_error <= framing_error_n;
        end
    end

    always_comb begin
        state_n         = state;
        tick_n          = tick_cnt;
        bit_n           = bit_cnt;
        shreg_n         = shreg;
        len_n           = len_q;
        par_n           = par_q;
        rx_par_n        = rx_par;
        data_n          = data;
        data_valid_n    = 1'b0;
        parity_error_n  = parity_error;
        framing_error_n = framing_error;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    tick_n  = '0;
                    len_n   = len_clamped;
                    par_n   = parity_type;
                end
            end

            START: begin
                if (tick_cnt == TICK_HALF) begin
                    if (!rx_s) begin
                        // Counters restart here so later samples land mid-bit.
                        state_n = DATA;
                        tick_n  = '0;
                        bit_n   = '0;
                        shreg_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    tick_n = tick_cnt + 1'b1;
                end
            end

            DATA: begin
                if (tick_cnt == TICK_LAST) begin
                    shreg_n[bit_cnt[2:0]] = rx_s;
                    bit_n  = bit_cnt + 4'd1;
                    tick_n = '0;
                    if (bit_cnt == len_q - 4'd1) begin
                        state_n = (par_q != 2'd2) ? PARITY : STOP;
                    end
                end else begin
                    tick_n = tick_cnt + 1'b1;
                end
            end

            PARITY: begin
                if (tick_cnt == TICK_LAST) begin
                    rx_par_n = rx_s;
                    tick_n   = '0;
                    state_n  = STOP;
                end else begin
                    tick_n = tick_cnt + 1'b1;
                end
            end

            STOP: begin
                if (tick_cnt == TICK_LAST) begin
                    // Leaving at mid stop bit keeps a back-to-back start edge visible.
                    data_n          = shreg;
                    data_valid_n    = 1'b1;
                    framing_error_n = ~rx_s;
                    case (par_q)
                        2'd0:    parity_error_n = word_par;
                        2'd1:    parity_error_n = ~word_par;
                        default: parity_error_n = 1'b0;
                    endcase
                    tick_n  = '0;
                    state_n = rx_s ? IDLE : WAIT_IDLE;
                end else begin
                    tick_n = tick_cnt + 1'b1;
                end
            end

            WAIT_IDLE: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer
//   Directed and randomized frames for uart_rx_deserializer. Expected words,
//   flags and valid-pulse times are derived from the frame contents with
//   plain arithmetic and compared against what the receiver reports.
module tb_uart_rx_deserializer;

    localparam int unsigned OS = 16;

    typedef struct {
        logic [7:0]  data;
        logic        perr;
        logic        ferr;
        int unsigned cyc;
    } rec_t;

    logic       baud_clk;
    logic       resetn;
    logic       serial_data_in;
    logic [3:0] data_length;
    logic [1:0] parity_type;
    logic [7:0] data;
    logic       data_valid;
    logic       parity_error;
    logic       framing_error;
    logic       rx_busy;

    int unsigned passes = 0;
    int unsigned fails  = 0;
    int unsigned cyc    = 0;

    rec_t exp_q[$];
    rec_t got_q[$];

    logic [7:0] last_data;
    logic       last_perr;
    logic       last_ferr;

    uart_rx_deserializer #(.OVERSAMPLE(OS)) dut (
        .baud_clk       (baud_clk),
        .resetn         (resetn),
        .serial_data_in (serial_data_in),
        .data_length    (data_length),
        .parity_type    (parity_type),
        .data           (data),
        .data_valid     (data_valid),
        .parity_error   (parity_error),
        .framing_error  (framing_error),
        .rx_busy        (rx_busy)
    );

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    always @(posedge baud_clk) cyc <= cyc + 1;

    // Every valid pulse is recorded with the edge index at which it rose.
    always @(negedge baud_clk) begin
        if (data_valid === 1'b1) begin
            rec_t r;
            r.data = data;
            r.perr = parity_error;
            r.ferr = framing_error;
            r.cyc  = cyc;
            got_q.push_back(r);
        end
    end

    initial begin
        #2000000;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge baud_clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        serial_data_in = b;
        tick(OS);
    endtask

    task automatic send_frame(input logic [7:0] word, input int unsigned len,
                              input int unsigned ptype, input logic parbit,
                              input logic stopbit);
        rec_t        e;
        int unsigned eff;
        int unsigned ones;
        int unsigned p;
        eff  = (len == 0 || len > 8) ? 8 : len;
        p    = (ptype != 2) ? 1 : 0;
        e.data = 8'(32'(word) & ((32'd1 << eff) - 32'd1));
        ones = $countones(e.data);
        if (ptype == 0)      e.perr = ((ones + int'(parbit)) % 2) != 0;
        else if (ptype == 1) e.perr = ((ones + int'(parbit)) % 2) != 1;
        else                 e.perr = 1'b0;
        e.ferr = ~stopbit;
        e.cyc  = cyc + 2 + OS / 2 + (eff + p + 1) * OS + 1;
        exp_q.push_back(e);
        data_length = 4'(len);
        parity_type = 2'(ptype);
        drive_bit(1'b0);
        // Config pins change mid-frame; the receiver must use the latched copy.
        data_length = 4'($urandom);
        parity_type = 2'($urandom);
        for (int i = 0; i < int'(eff); i++) drive_bit(word[i]);
        if (ptype != 2) drive_bit(parbit);
        drive_bit(stopbit);
    endtask

    task automatic expect_frame(input string name);
        rec_t        g;
        rec_t        w;
        int unsigned n;
        n = 0;
        while (got_q.size() == 0 && n < 4 * OS) begin
            @(posedge baud_clk);
            n++;
        end
        if (n > 0) #1;
        check({name, "_pulse"}, 32'(got_q.size() != 0), 32'd1);
        if (got_q.size() != 0 && exp_q.size() != 0) begin
            g = got_q.pop_front();
            w = exp_q.pop_front();
            check({name, "_data"}, 32'(g.data), 32'(w.data));
            check({name, "_perr"}, 32'(g.perr), 32'(w.perr));
            check({name, "_ferr"}, 32'(g.ferr), 32'(w.ferr));
            check({name, "_latency"}, g.cyc, w.cyc);
            last_data = w.data;
            last_perr = w.perr;
            last_ferr = w.ferr;
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
    endtask

    task automatic check_no_pulse(input string name);
        check(name, got_q.size(), 32'd0);
        got_q.delete();
    endtask

    task automatic check_hold(input string name);
        check({name, "_data"}, 32'(data), 32'(last_data));
        check({name, "_perr"}, 32'(parity_error), 32'(last_perr));
        check({name, "_ferr"}, 32'(framing_error), 32'(last_ferr));
    endtask

    initial begin
        logic [7:0]  w;
        int unsigned len;
        int unsigned pt;
        logic        pb;
        logic        sb;

        resetn         = 1'b0;
        serial_data_in = 1'b1;
        data_length    = 4'd8;
        parity_type    = 2'd2;
        tick(3);
        check("rst_data", 32'(data), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_perr", 32'(parity_error), 32'd0);
        check("rst_ferr", 32'(framing_error), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        last_data = 8'h00;
        last_perr = 1'b0;
        last_ferr = 1'b0;
        resetn = 1'b1;
        tick(5);

        // 8N1 0xA5
        send_frame(8'hA5, 8, 2, 1'b0, 1'b1);
        tick(4);
        expect_frame("8n1_a5");
        check_no_pulse("8n1_a5_extra");
        check("8n1_idle_busy", 32'(rx_busy), 32'd0);

        // 7E1 0x55 with correct and wrong parity bit
        send_frame(8'h55, 7, 0, 1'b0, 1'b1);
        tick(4);
        expect_frame("7e1_ok");
        send_frame(8'h55, 7, 0, 1'b1, 1'b1);
        tick(4);
        expect_frame("7e1_bad");
        check_no_pulse("7e1_extra");

        // 5O1 0x13
        send_frame(8'h13, 5, 1, 1'b0, 1'b1);
        tick(4);
        expect_frame("5o1_13");
        check_no_pulse("5o1_extra");

        // Start glitch: four low cycles
        serial_data_in = 1'b0;
        tick(4);
        check("glitch_busy_on", 32'(rx_busy), 32'd1);
        serial_data_in = 1'b1;
        tick(2 * OS);
        check("glitch_busy_off", 32'(rx_busy), 32'd0);
        check_no_pulse("glitch_no_pulse");
        check_hold("glitch_hold");

        // Framing error followed by a long break
        send_frame(8'h3C, 8, 2, 1'b0, 1'b0);
        tick(40 * OS);
        expect_frame("break_3c");
        check_no_pulse("break_extra");
        check("break_busy", 32'(rx_busy), 32'd1);
        serial_data_in = 1'b1;
        tick(4);
        check("break_release", 32'(rx_busy), 32'd0);
        send_frame(8'h81, 8, 2, 1'b0, 1'b1);
        tick(4);
        expect_frame("after_break_81");
        check_no_pulse("after_break_extra");

        // Reset during data bit 3 of 0x5A
        w = 8'h5A;
        data_length = 4'd8;
        parity_type = 2'd2;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(w[i]);
        serial_data_in = w[3];
        tick(OS / 2);
        resetn = 1'b0;
        serial_data_in = 1'b1;
        tick(1);
        resetn = 1'b1;
        check("midrst_busy", 32'(rx_busy), 32'd0);
        last_data = 8'h00;
        last_perr = 1'b0;
        last_ferr = 1'b0;
        check_hold("midrst_clear");
        tick(2 * OS);
        check_no_pulse("midrst_no_pulse");
        send_frame(8'hF0, 8, 2, 1'b0, 1'b1);
        tick(4);
        expect_frame("midrst_f0");
        check_no_pulse("midrst_extra");

        // Back-to-back frames without an idle gap
        send_frame(8'h01, 8, 2, 1'b0, 1'b1);
        send_frame(8'hFE, 8, 2, 1'b0, 1'b1);
        tick(4);
        expect_frame("b2b_01");
        expect_frame("b2b_fe");
        check_no_pulse("b2b_extra");

        // Randomized frames
        for (int r = 0; r < 10; r++) begin
            w   = 8'($urandom);
            len = $urandom_range(0, 15);
            pt  = $urandom_range(0, 3);
            pb  = 1'($urandom);
            sb  = ($urandom_range(0, 3) != 0);
            send_frame(w, len, pt, pb, sb);
            serial_data_in = 1'b1;
            tick($urandom_range(4, 20));
            expect_frame("rand");
            check_no_pulse("rand_extra");
            check_hold("rand_hold");
        end

        $display("%0d/%0d checks passed", passes, passes + fails);
        $finish;
    end

endmodule
